// File: rtl/dff_pkg.sv
// Shared defaults and helpers for the D_flip_flop tap-select family.
// Imported by the tap delay line and its register stage.
package dff_pkg;

    localparam int DFF_WIDTH = 8;
    localparam int DFF_DEPTH = 4;

    // Width of a select that can address taps 0..depth.
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tap_delay_line_if.sv
// Data/tap-select bundle for the tap delay line.
// master drives the chain and select, slave returns tap and status.
interface tap_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);

    logic             en;
    logic             flush;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             sel_err;
    logic             full;
    logic             empty;

    modport master (
        output en, flush, din, din_valid, sel,
        input  q, q_valid, sel_err, full, empty
    );

    modport slave (
        input  en, flush, din, din_valid, sel,
        output q, q_valid, sel_err, full, empty
    );

endinterface

// File: rtl/dff_stage.sv
// One register stage: W bits with sync reset, flush and enable.
// Reset beats flush, flush beats enable.
module dff_stage #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic [W-1:0] r_d;

    // Next value: clear on flush, load on enable, otherwise hold.
    always_comb begin
        r_d = r_q;
        if (flush) begin
            r_d = '0;
        end else if (en) begin
            r_d = d;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tap_delay_line.sv
// Parametrised DEPTH-stage delay line with runtime tap select.
// Define TAP_DELAY_OUTREG_EN to register q, q_valid and sel_err.
module tap_delay_line
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_WIDTH,
    parameter int DEPTH = DFF_DEPTH
) (
    input logic             clk,
    input logic             reset,
    tap_delay_line_if.slave bus
);

    localparam int SEL_W = sel_w(DEPTH);

    // tap[0] is the live input, tap[k] is the output of stage k.
    // The valid bit rides in the top bit of each word.
    logic [DEPTH:0][WIDTH:0] tap;
    logic [DEPTH-1:0]        vld;

    logic [WIDTH-1:0] mux_q;
    logic             mux_v;
    logic             mux_err;

    assign tap[0] = {bus.din_valid, bus.din};

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        dff_stage #(
            .W(WIDTH + 1)
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .flush(bus.flush),
            .en   (bus.en),
            .d    (tap[k-1]),
            .q    (tap[k])
        );
    end

    // Gather the per-stage valid bits for the status flags.
    always_comb begin
        vld = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            vld[k-1] = tap[k][WIDTH];
        end
    end

    assign bus.full  = &vld;
    assign bus.empty = ~|vld;

    // Tap mux; out-of-range selects yield zero and flag an error.
    always_comb begin
        mux_q   = '0;
        mux_v   = 1'b0;
        mux_err = 1'b1;
        for (int k = 0; k <= DEPTH; k++) begin
            if (int'(bus.sel) == k) begin
                mux_q   = tap[k][WIDTH-1:0];
                mux_v   = tap[k][WIDTH];
                mux_err = 1'b0;
            end
        end
    end

`ifdef TAP_DELAY_OUTREG_EN
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             q_valid_q;
    logic             q_valid_d;
    logic             sel_err_q;
    logic             sel_err_d;

    // Output register follows the mux every cycle; flush clears it.
    always_comb begin
        q_d       = mux_q;
        q_valid_d = mux_v;
        sel_err_d = mux_err;
        if (bus.flush) begin
            q_d       = '0;
            q_valid_d = 1'b0;
            sel_err_d = 1'b0;
        end
    end

    // Output register with synchronous reset, independent of en.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.sel_err = sel_err_q;
`else
    assign bus.q       = mux_q;
    assign bus.q_valid = mux_v;
    assign bus.sel_err = mux_err;
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// Self-checking bench for tap_delay_line (WIDTH=8, DEPTH=4).
// Directed vector table, random run against a queue model, latency probe.
module tb_tap_delay_line;

    import dff_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SW = sel_w(D);
`ifdef TAP_DELAY_OUTREG_EN
    localparam int OLAT = 1;
`else
    localparam int OLAT = 0;
`endif

    logic clk = 1'b0;
    logic reset;

    tap_delay_line_if #(.WIDTH(W), .SEL_W(SW)) bus ();

    tap_delay_line #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
    } word_t;

    typedef struct {
        logic         rst;
        logic         fl;
        logic         en;
        logic [W-1:0] din;
        logic         dv;
        logic [SW-1:0] sel;
        logic [W-1:0] eq;
        logic         eqv;
        logic         eerr;
        logic         efull;
        logic         eempty;
    } vec_t;

    // chain[0] is stage 1, chain[D-1] is stage D
    word_t chain[$];
    vec_t  vecs[$];

    logic [W-1:0] oq;
    logic         oqv;
    logic         oerr;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_tap(input logic [SW-1:0] s,
                                      input logic [W-1:0] din,
                                      input logic dv,
                                      output logic [W-1:0] q,
                                      output logic qv,
                                      output logic err);
        int k;
        k = int'(s);
        q = '0;
        qv = 1'b0;
        err = 1'b0;
        if (k == 0) begin
            q = din;
            qv = dv;
        end else if (k <= D) begin
            q = chain[k-1].d;
            qv = chain[k-1].v;
        end else begin
            err = 1'b1;
        end
    endfunction

    function automatic logic model_full();
        foreach (chain[i]) if (!chain[i].v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_empty();
        foreach (chain[i]) if (chain[i].v) return 1'b0;
        return 1'b1;
    endfunction

    // One clock edge: advance the model from the applied inputs.
    task automatic tick();
        logic [W-1:0] cq;
        logic cqv, cerr;
        @(posedge clk);
        model_tap(bus.sel, bus.din, bus.din_valid, cq, cqv, cerr);
        if (reset || bus.flush) begin
            oq = '0;
            oqv = 1'b0;
            oerr = 1'b0;
            foreach (chain[i]) chain[i] = word_t'{'0, 1'b0};
        end else begin
            oq = cq;
            oqv = cqv;
            oerr = cerr;
            if (bus.en) begin
                chain.push_front(word_t'{bus.din, bus.din_valid});
                void'(chain.pop_back());
            end
        end
        @(negedge clk);
    endtask

    task automatic add(input logic rst, input logic fl, input logic en,
                       input logic [W-1:0] din, input logic dv,
                       input int sel, input logic [W-1:0] eq,
                       input logic eqv, input logic eerr,
                       input logic efull, input logic eempty);
        vec_t v;
        v.rst = rst; v.fl = fl; v.en = en; v.din = din; v.dv = dv;
        v.sel = SW'(sel); v.eq = eq; v.eqv = eqv; v.eerr = eerr;
        v.efull = efull; v.eempty = eempty;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic fl, input logic en,
                         input logic [W-1:0] din, input logic dv,
                         input logic [SW-1:0] sel);
        reset = rst;
        bus.flush = fl;
        bus.en = en;
        bus.din = din;
        bus.din_valid = dv;
        bus.sel = sel;
    endtask

    initial begin
        logic [W-1:0] pq, eq;
        logic pqv, perr, eqv, eerr;
        int lat;

        // rst fl en din dv sel | q qv err full empty
        // fill A1..D4
        add(0, 0, 1, 8'hA1, 1, 0, 8'hA1, 1, 0, 0, 1);
        add(0, 0, 1, 8'hB2, 1, 1, 8'hA1, 1, 0, 0, 0);
        add(0, 0, 1, 8'hC3, 1, 2, 8'hA1, 1, 0, 0, 0);
        add(0, 0, 1, 8'hD4, 1, 3, 8'hA1, 1, 0, 0, 0);
        // read taps, hold with din toggling
        add(0, 0, 0, 8'h00, 0, 1, 8'hD4, 1, 0, 1, 0);
        add(0, 0, 0, 8'h55, 1, 2, 8'hC3, 1, 0, 1, 0);
        add(0, 0, 0, 8'hAA, 0, 3, 8'hB2, 1, 0, 1, 0);
        add(0, 0, 0, 8'h5E, 1, 4, 8'hA1, 1, 0, 1, 0);
        // bypass and range
        add(0, 0, 0, 8'h5E, 1, 0, 8'h5E, 1, 0, 1, 0);
        add(0, 0, 0, 8'h77, 1, 5, 8'h00, 0, 1, 1, 0);
        add(0, 0, 0, 8'h77, 1, 7, 8'h00, 0, 1, 1, 0);
        add(0, 0, 0, 8'h77, 1, 4, 8'hA1, 1, 0, 1, 0);
        // flush with en and din=FF
        add(0, 1, 1, 8'hFF, 1, 4, 8'hA1, 1, 0, 1, 0);
        add(0, 0, 0, 8'hFF, 1, 1, 8'h00, 0, 0, 0, 1);
        add(0, 0, 0, 8'hFF, 1, 4, 8'h00, 0, 0, 0, 1);
        // valid bubble
        add(0, 0, 1, 8'hA1, 1, 0, 8'hA1, 1, 0, 0, 1);
        add(0, 0, 1, 8'h3C, 0, 0, 8'h3C, 0, 0, 0, 0);
        add(0, 0, 1, 8'hC3, 1, 1, 8'h3C, 0, 0, 0, 0);
        add(0, 0, 0, 8'h00, 0, 2, 8'h3C, 0, 0, 0, 0);
        add(0, 0, 0, 8'h00, 0, 1, 8'hC3, 1, 0, 0, 0);
        add(0, 0, 0, 8'h00, 0, 3, 8'hA1, 1, 0, 0, 0);
        add(0, 0, 0, 8'h00, 0, 4, 8'h00, 0, 0, 0, 0);
        // refill then reset with en and din=FF
        add(0, 0, 1, 8'h11, 1, 0, 8'h11, 1, 0, 0, 0);
        add(0, 0, 1, 8'h22, 1, 0, 8'h22, 1, 0, 0, 0);
        add(0, 0, 1, 8'h33, 1, 0, 8'h33, 1, 0, 0, 0);
        add(0, 0, 1, 8'h44, 1, 0, 8'h44, 1, 0, 1, 0);
        add(1, 0, 1, 8'hFF, 1, 4, 8'h11, 1, 0, 1, 0);
        add(0, 0, 0, 8'hFF, 1, 4, 8'h00, 0, 0, 0, 1);
        add(0, 0, 0, 8'hFF, 1, 2, 8'h00, 0, 0, 0, 1);

        for (int i = 0; i < D; i++) chain.push_back(word_t'{'0, 1'b0});
        oq = '0; oqv = 1'b0; oerr = 1'b0;

        drive(1, 0, 0, '0, 0, SW'(2));
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_q", bus.q, 0);
        chk("rst_qv", bus.q_valid, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_empty", bus.empty, 1);

        pq = '0; pqv = 1'b0; perr = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].en,
                  vecs[i].din, vecs[i].dv, vecs[i].sel);
            #1;
            if (OLAT == 1) begin
                eq = pq; eqv = pqv; eerr = perr;
            end else begin
                eq = vecs[i].eq; eqv = vecs[i].eqv; eerr = vecs[i].eerr;
            end
            chk($sformatf("v%0d_q", i), bus.q, eq);
            chk($sformatf("v%0d_qv", i), bus.q_valid, eqv);
            chk($sformatf("v%0d_err", i), bus.sel_err, eerr);
            chk($sformatf("v%0d_full", i), bus.full, vecs[i].efull);
            chk($sformatf("v%0d_empty", i), bus.empty, vecs[i].eempty);
            if (vecs[i].rst || vecs[i].fl) begin
                pq = '0; pqv = 1'b0; perr = 1'b0;
            end else begin
                pq = vecs[i].eq; pqv = vecs[i].eqv; perr = vecs[i].eerr;
            end
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 70, W'($urandom),
                  1'($urandom), SW'($urandom_range(0, (1 << SW) - 1)));
            #1;
            if (OLAT == 1) begin
                eq = oq; eqv = oqv; eerr = oerr;
            end else begin
                model_tap(bus.sel, bus.din, bus.din_valid, eq, eqv, eerr);
            end
            chk("rnd_q", bus.q, eq);
            chk("rnd_qv", bus.q_valid, eqv);
            chk("rnd_err", bus.sel_err, eerr);
            chk("rnd_full", bus.full, model_full());
            chk("rnd_empty", bus.empty, model_empty());
            tick();
        end

        // latency probe: one valid word, read at the last tap
        drive(1, 0, 0, '0, 0, SW'(D));
        tick();
        drive(0, 0, 1, 8'h5A, 1, SW'(D));
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                bus.din = '0;
                bus.din_valid = 1'b0;
            end
            if (bus.q_valid && bus.q == 8'h5A) begin
                lat = n;
                break;
            end
        end
        chk("latency", lat, D + OLAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tap_delay_line.md
Name: tap_delay_line

Overview:
- Parametrised successor to the fixed 4-stage, 8-bit DFF chain with a 2-bit tap select.
- A WIDTH-bit data word shifts through a DEPTH-stage register chain. A per-stage valid bit travels alongside each word.
- A runtime tap select drives any tap, 0..DEPTH, onto the output. Shift enable, synchronous flush and full/empty status are added.
- Used as a programmable delay / alignment element in datapaths built from the D_flip_flop family.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- SEL_W, $clog2(DEPTH+1), tap-select width (derived; not overridden)

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- en  input  1  shift enable; chain advances only when high
- flush  input  1  synchronous clear of data and valid chain
- din  input  WIDTH  data into stage 1
- din_valid  input  1  valid bit accompanying din
- sel  input  SEL_W  tap select: 0 = din, k = output of stage k
- q  output  WIDTH  selected tap data
- q_valid  output  1  valid bit of selected tap
- sel_err  output  1  high when sel > DEPTH
- full  output  1  all DEPTH valid bits set
- empty  output  1  no valid bits set

Behaviour:
- State: stage[1..DEPTH] (WIDTH bits each), vld[1..DEPTH].
- Reset (sync, highest priority): all stage = 0, all vld = 0.
  - Outputs after reset: q = 0 and q_valid = 0 for sel != 0; full = 0; empty = 1; sel_err follows sel.
- Priority order: reset > flush > en.
- flush: same clear as reset, one cycle. Status after flush: empty = 1, full = 0.
- en = 1, no flush/reset, on posedge:
  - stage[1] <= din; vld[1] <= din_valid
  - stage[k] <= stage[k-1]; vld[k] <= vld[k-1], for k = 2..DEPTH
  - The word in stage[DEPTH] is discarded.
- en = 0: all stage and vld hold.
- Tap mux (combinational on sel):
  - sel = 0: q = din, q_valid = din_valid (zero latency).
  - sel = k, 1 <= k <= DEPTH: q = stage[k], q_valid = vld[k]. Latency is k enabled cycles.
  - sel > DEPTH: q = 0, q_valid = 0, sel_err = 1. State is unaffected.
- full = AND of vld[1..DEPTH]; empty = NOR of vld[1..DEPTH]. Both are combinational from registers.
- Invalid words (din_valid = 0) still shift their data. Their valid bit is 0; data content is don't-care but deterministic.
- sel changes any cycle without disturbing state; q reflects the new tap in the same cycle.
- Reset or flush mid-stream discards all in-flight words; the chain refills from stage 1 on the next enabled cycles.
- DEPTH = 1 is legal: SEL_W = 1, taps 0 and 1 only.

Optional Feature:
- Macro: TAP_DELAY_OUTREG_EN.
- Defined:
  - q, q_valid and sel_err are registered; each tap gains one cycle of latency.
  - The output register updates every cycle regardless of en.
  - Reset/flush clear it to q = 0, q_valid = 0, sel_err = 0.
- Undefined: outputs are combinational as above.
- full and empty are unaffected in both builds.

Decomposition:
- Package dff_pkg: default WIDTH/DEPTH localparams; a sel-width helper function (clog2 of DEPTH+1) shared with other tap-select blocks.
- Sub-module dff_stage: one WIDTH+1-bit register with sync reset, flush and enable. It is instantiated DEPTH times via generate.
- Tap mux and status logic live in the top.

Test Plan:
- Shift and tap read: reset, en = 1, din_valid = 1, din = A1, B2, C3, D4 on four cycles, then en = 0.
  - sel = 1, 2, 3, 4 -> q = D4, C3, B2, A1; q_valid = 1; full = 1.
- Bypass and range check: sel = 0, din = 5E -> q = 5E same cycle. With DEPTH = 4, sel = 5 -> q = 00, q_valid = 0, sel_err = 1.
- Hold: after the fill above, en = 0 for 3 cycles with din toggling -> sel = 4 still reads A1; full stays 1.
- Valid bubble: push A1(v=1), xx(v=0), C3(v=1) -> sel = 2 gives q_valid = 0, sel = 1 and sel = 3 give q_valid = 1; full = 0, empty = 0.
- Flush priority: full chain, assert flush and en together with din = FF -> next cycle all taps 00, empty = 1, full = 0. A second run with reset instead of flush gives the same result.
- TAP_DELAY_OUTREG_EN build, DEPTH = 8, WIDTH = 16: push 0x1234 and read sel = 8 -> q = 0x1234 appears exactly 9 cycles after the push.
